conv_psum_quant: RTL and testbench

- Consumes the 20-bit signed 3x3 partial sums from the adder-tree stage.
- Accumulates them across cfg_num_grp input-channel groups and preloads the bias on the first group.
- Requantizes the final sum to int8 by round-to-nearest plus arithmetic right shift, then saturates.
- Emits one output pixel per output channel and position. Sits between the adder tree and the output feature-map writer.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_psum_quant_if.sv | 31 +++
 rtl/requant_sat.sv | 86 ++++++++
 rtl/conv_psum_quant.sv | 96 +++++++++
 tb/tb_conv_psum_quant.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution partial-sum / requant path.
//   SUM_W  : adder-tree partial-sum width (signed)
//   ACC_W  : accumulator width (signed)
//   BIAS_W : bias width (signed)
//   OUT_W  : quantized output width (signed int8)
//   GRP_W  : group counter / cfg_num_grp width
//   state_t: accumulation FSM state
package conv_pkg;

    localparam int unsigned SUM_W  = 20;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned BIAS_W = 16;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned GRP_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/conv_psum_quant_if.sv
// Partial-sum input / quantized-pixel output bundle for conv_psum_quant.
// Signal names carry the direction as seen from the accumulator (slave side).
//   sum_vld_i/sum_i : partial-sum beat (no backpressure)
//   bias_i          : bias, sampled on the first beat of a pixel
//   clr_i           : synchronous abort of the partial accumulation
//   out_vld_o/out_data_o : quantized pixel
//   acc_busy_o      : pixel partially accumulated
//   ovf_o           : sticky accumulator overflow
interface conv_psum_quant_if;
    import conv_pkg::*;

    logic                     sum_vld_i;
    logic signed [SUM_W-1:0]  sum_i;
    logic signed [BIAS_W-1:0] bias_i;
    logic                     clr_i;
    logic                     out_vld_o;
    logic signed [OUT_W-1:0]  out_data_o;
    logic                     acc_busy_o;
    logic                     ovf_o;

    modport slave (
        input  sum_vld_i, sum_i, bias_i, clr_i,
        output out_vld_o, out_data_o, acc_busy_o, ovf_o
    );

    modport master (
        output sum_vld_i, sum_i, bias_i, clr_i,
        input  out_vld_o, out_data_o, acc_busy_o, ovf_o
    );

endinterface

// File: rtl/requant_sat.sv
// Two-stage requantization pipeline: Q1 adds the round-to-nearest constant,
// Q2 arithmetic-shifts and saturates to OUT_W bits. Latency 2 cycles.
// With PSUM_QUANT_RELU_EN defined, Q2 clamps to [0, max] (fused ReLU)
// instead of signed saturation; latency is unchanged.
//   clk, rst   : clock, asynchronous active-high reset
//   shift_i    : right-shift amount 0..31, stable while data is in flight
//   in_vld_i   : input valid
//   in_data_i  : signed accumulator value
//   out_vld_o  : one-cycle output valid
//   out_data_o : saturated result, holds when out_vld_o=0
module requant_sat
    import conv_pkg::*;
#(
    parameter int unsigned AccW = ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              shift_i,
    input  logic                    in_vld_i,
    input  logic signed [AccW-1:0]  in_data_i,
    output logic                    out_vld_o,
    output logic signed [OUT_W-1:0] out_data_o
);

    localparam int unsigned RW = AccW + 1;
    localparam logic signed [AccW:0] SatMax = RW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [AccW:0] SatMin = ~SatMax;

    logic signed [AccW:0]    rnd;
    logic signed [AccW:0]    r_d;
    logic signed [AccW:0]    r_q;
    logic signed [AccW:0]    shifted;
    logic signed [OUT_W-1:0] sat_d;
    logic                    q1_vld_q;
    logic                    out_vld_q;
    logic signed [OUT_W-1:0] out_data_q;

    // One extra bit so the rounding add cannot wrap.
    always_comb begin
        rnd = '0;
        if (shift_i != 5'd0) begin
            rnd = RW'(1) << (shift_i - 5'd1);
        end
        r_d = RW'(in_data_i) + rnd;
    end

    always_comb begin
        shifted = r_q >>> shift_i;
        sat_d   = shifted[OUT_W-1:0];
`ifdef PSUM_QUANT_RELU_EN
        if (shifted[AccW]) begin
            sat_d = '0;
        end else if (shifted > SatMax) begin
            sat_d = SatMax[OUT_W-1:0];
        end
`else
        if (shifted > SatMax) begin
            sat_d = SatMax[OUT_W-1:0];
        end else if (shifted < SatMin) begin
            sat_d = SatMin[OUT_W-1:0];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_vld_q   <= 1'b0;
            r_q        <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            q1_vld_q  <= in_vld_i;
            out_vld_q <= q1_vld_q;
            if (in_vld_i) begin
                r_q <= r_d;
            end
            if (q1_vld_q) begin
                out_data_q <= sat_d;
            end
        end
    end

    assign out_vld_o  = out_vld_q;
    assign out_data_o = out_data_q;

endmodule

// File: rtl/conv_psum_quant.sv
// Accumulates 3x3 partial sums over cfg_num_grp input-channel groups (bias
// preloaded on the first beat), then requantizes to int8 through requant_sat.
// Optional feature macro: PSUM_QUANT_RELU_EN (fused ReLU in requant_sat).
//   clk, rst    : clock, asynchronous active-high reset
//   cfg_num_grp : groups per output pixel (0 treated as 1)
//   cfg_shift   : requant right-shift amount
//   bus         : partial-sum in / pixel out bundle (slave side)
module conv_psum_quant
    import conv_pkg::*;
#(
    parameter int unsigned AccW = ACC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [GRP_W-1:0]     cfg_num_grp,
    input  logic [4:0]           cfg_shift,
    conv_psum_quant_if.slave     bus
);

    state_t                 state_q;
    logic [GRP_W-1:0]       grp_cnt_q;
    logic signed [AccW-1:0] acc_q;
    logic                   ovf_q;
    logic                   iss_vld_q;

    logic [GRP_W-1:0]       num_eff;
    logic                   last_beat;
    logic signed [AccW-1:0] op_a;
    logic signed [AccW-1:0] op_b;
    logic signed [AccW-1:0] add_res;
    logic                   add_ovf;

    always_comb begin
        num_eff = (cfg_num_grp == '0) ? GRP_W'(1) : cfg_num_grp;
        if (state_q == IDLE) begin
            last_beat = (num_eff == GRP_W'(1));
            op_a      = AccW'(bus.bias_i);
        end else begin
            last_beat = (grp_cnt_q == num_eff - GRP_W'(1));
            op_a      = acc_q;
        end
        op_b    = AccW'(bus.sum_i);
        add_res = op_a + op_b;
        // Same-sign operands with a differently signed result: wrapped.
        add_ovf = (op_a[AccW-1] == op_b[AccW-1]) && (add_res[AccW-1] != op_a[AccW-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grp_cnt_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            iss_vld_q <= 1'b0;
        end else begin
            iss_vld_q <= 1'b0;
            if (bus.clr_i) begin
                // Abort wins over a same-cycle beat; in-flight pixels still finish.
                state_q   <= IDLE;
                grp_cnt_q <= '0;
                acc_q     <= '0;
                ovf_q     <= 1'b0;
            end else if (bus.sum_vld_i) begin
                acc_q <= add_res;
                if (add_ovf) begin
                    ovf_q <= 1'b1;
                end
                if (last_beat) begin
                    iss_vld_q <= 1'b1;
                    grp_cnt_q <= '0;
                    state_q   <= IDLE;
                end else begin
                    grp_cnt_q <= grp_cnt_q + GRP_W'(1);
                    state_q   <= ACC;
                end
            end
        end
    end

    // acc_q holds the final sum for exactly the cycle iss_vld_q is high.
    requant_sat #(
        .AccW (AccW)
    ) u_requant_sat (
        .clk        (clk),
        .rst        (rst),
        .shift_i    (cfg_shift),
        .in_vld_i   (iss_vld_q),
        .in_data_i  (acc_q),
        .out_vld_o  (bus.out_vld_o),
        .out_data_o (bus.out_data_o)
    );

    assign bus.acc_busy_o = (grp_cnt_q != '0);
    assign bus.ovf_o      = ovf_q;

endmodule

// File: tb/tb_conv_psum_quant.sv
module tb_conv_psum_quant;
    import conv_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [GRP_W-1:0] cfg_num_grp;
    logic [4:0]       cfg_shift;
    int               errors = 0;
    int               checks = 0;
    int               exp_neg;

    conv_psum_quant_if bus_a ();
    conv_psum_quant_if bus_b ();

    // Narrow-accumulator copy sees identical stimulus.
    assign bus_b.sum_vld_i = bus_a.sum_vld_i;
    assign bus_b.sum_i     = bus_a.sum_i;
    assign bus_b.bias_i    = bus_a.bias_i;
    assign bus_b.clr_i     = bus_a.clr_i;

    conv_psum_quant u_dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_num_grp (cfg_num_grp),
        .cfg_shift   (cfg_shift),
        .bus         (bus_a)
    );

    conv_psum_quant #(
        .AccW (24)
    ) u_dut_narrow (
        .clk         (clk),
        .rst         (rst),
        .cfg_num_grp (cfg_num_grp),
        .cfg_shift   (cfg_shift),
        .bus         (bus_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input int v);
        bus_a.sum_vld_i = 1'b1;
        bus_a.sum_i     = SUM_W'(v);
        step();
        bus_a.sum_vld_i = 1'b0;
    endtask

    task automatic clr_pulse();
        bus_a.clr_i = 1'b1;
        step();
        bus_a.clr_i = 1'b0;
    endtask

    initial begin
`ifdef PSUM_QUANT_RELU_EN
        exp_neg = 0;
`else
        exp_neg = -128;
`endif
        rst             = 1'b1;
        cfg_num_grp     = 8'd1;
        cfg_shift       = 5'd0;
        bus_a.sum_vld_i = 1'b0;
        bus_a.sum_i     = '0;
        bus_a.bias_i    = '0;
        bus_a.clr_i     = 1'b0;
        #12;
        chk("rst_out_vld", bus_a.out_vld_o, 0);
        chk("rst_out_data", bus_a.out_data_o, 0);
        chk("rst_busy", bus_a.acc_busy_o, 0);
        chk("rst_ovf", bus_a.ovf_o, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Basic: 100 + 1000 - 200 + 300 = 1200; (1200+8)>>>4 = 75.
        cfg_num_grp  = 8'd3;
        cfg_shift    = 5'd4;
        bus_a.bias_i = 16'sd100;
        beat(1000);
        chk("basic_busy_mid", bus_a.acc_busy_o, 1);
        beat(-200);
        beat(300);
        chk("basic_busy_end", bus_a.acc_busy_o, 0);
        chk("basic_vld_n0", bus_a.out_vld_o, 0);
        step();
        chk("basic_vld_n1", bus_a.out_vld_o, 0);
        step();
        chk("basic_vld_n2", bus_a.out_vld_o, 1);
        chk("basic_data", bus_a.out_data_o, 75);
        step();
        chk("basic_vld_off", bus_a.out_vld_o, 0);
        chk("basic_hold", bus_a.out_data_o, 75);

        // Saturation: (-5000+2)>>>2 = -1250, (5000+2)>>>2 = 1250.
        cfg_num_grp  = 8'd1;
        cfg_shift    = 5'd2;
        bus_a.bias_i = '0;
        beat(-5000);
        step();
        step();
        chk("sat_neg_vld", bus_a.out_vld_o, 1);
        chk("sat_neg_data", bus_a.out_data_o, exp_neg);
        beat(5000);
        step();
        step();
        chk("sat_pos_vld", bus_a.out_vld_o, 1);
        chk("sat_pos_data", bus_a.out_data_o, 127);

        // Back-to-back pixels: 5+7 = 12, -3-4 = -7.
        cfg_num_grp = 8'd2;
        cfg_shift   = 5'd0;
        beat(5);
        beat(7);
        beat(-3);
        beat(-4);
        chk("b2b_vld_1", bus_a.out_vld_o, 1);
        chk("b2b_data_1", bus_a.out_data_o, 12);
        step();
        chk("b2b_gap_vld", bus_a.out_vld_o, 0);
        step();
        chk("b2b_vld_2", bus_a.out_vld_o, 1);
        chk("b2b_data_2", bus_a.out_data_o, -7);

        // Same pixels with idle cycles between beats.
        beat(5);
        step();
        chk("gap_busy", bus_a.acc_busy_o, 1);
        beat(7);
        step();
        beat(-3);
        chk("gap_vld_1", bus_a.out_vld_o, 1);
        chk("gap_data_1", bus_a.out_data_o, 12);
        step();
        beat(-4);
        step();
        step();
        chk("gap_vld_2", bus_a.out_vld_o, 1);
        chk("gap_data_2", bus_a.out_data_o, -7);

        // Abort with the third beat, then a clean 4-beat pixel of ones.
        cfg_num_grp = 8'd4;
        beat(9);
        beat(9);
        bus_a.clr_i     = 1'b1;
        bus_a.sum_vld_i = 1'b1;
        bus_a.sum_i     = SUM_W'(9);
        step();
        bus_a.clr_i     = 1'b0;
        bus_a.sum_vld_i = 1'b0;
        chk("clr_busy", bus_a.acc_busy_o, 0);
        step();
        step();
        chk("clr_no_out", bus_a.out_vld_o, 0);
        beat(1);
        chk("clr_busy_new", bus_a.acc_busy_o, 1);
        beat(1);
        beat(1);
        chk("clr_no_early", bus_a.out_vld_o, 0);
        beat(1);
        step();
        step();
        chk("clr_vld", bus_a.out_vld_o, 1);
        chk("clr_data", bus_a.out_data_o, 4);

        // Overflow: 255 beats of +524287 on bias 32767. 32-bit never wraps;
        // 24-bit wraps on beat 16 (32767 + 16*524287 = 8421359 > 8388607).
        cfg_num_grp  = 8'd255;
        cfg_shift    = 5'd31;
        bus_a.bias_i = 16'sd32767;
        clr_pulse();
        for (int i = 0; i < 15; i++) beat(524287);
        chk("ovf_narrow_b15", bus_b.ovf_o, 0);
        beat(524287);
        chk("ovf_narrow_b16", bus_b.ovf_o, 1);
        chk("ovf_wide_b16", bus_a.ovf_o, 0);
        for (int i = 16; i < 255; i++) beat(524287);
        step();
        step();
        chk("ovf_wide_vld", bus_a.out_vld_o, 1);
        chk("ovf_wide_data", bus_a.out_data_o, 0);
        chk("ovf_wide_flag", bus_a.ovf_o, 0);
        chk("ovf_narrow_sticky", bus_b.ovf_o, 1);
        clr_pulse();
        chk("ovf_narrow_clr", bus_b.ovf_o, 0);

        // Reset while a pixel is in Q1.
        cfg_num_grp  = 8'd1;
        cfg_shift    = 5'd2;
        bus_a.bias_i = '0;
        beat(40);
        step();
        step();
        chk("pre_rst_data", bus_a.out_data_o, 10);
        beat(400);
        step();
        rst = 1'b1;
        #2;
        chk("mid_rst_vld", bus_a.out_vld_o, 0);
        chk("mid_rst_data", bus_a.out_data_o, 0);
        chk("mid_rst_busy", bus_a.acc_busy_o, 0);
        step();
        step();
        chk("mid_rst_no_pulse", bus_a.out_vld_o, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        beat(16);
        step();
        step();
        chk("post_rst_vld", bus_a.out_vld_o, 1);
        chk("post_rst_data", bus_a.out_data_o, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
